// File: rtl/q2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : q2_pkg
// Purpose  : Shared state codes and defaults for the Q2 sequencer and control decoder.
// Revision : 1.0 - initial release
// ============================================================================
package q2_pkg;

   localparam logic [3:0] ST_FETCH = 4'b0000;
   localparam logic [3:0] ST_ADDR  = 4'b0001;
   localparam logic [3:0] ST_LOAD  = 4'b0010;
   localparam logic [3:0] ST_EXEC  = 4'b0011;
   localparam logic [3:0] ST_ALU0  = 4'b0100;

   localparam int ALU_STEPS_DEF = 8;

   typedef enum logic {
      PH_SETTLE = 1'b0,
      PH_WRITE  = 1'b1
   } phase_e;

   // FETCH, ADDR, LOAD and EXEC touch memory; every code above them is an ALU step.
   function automatic logic is_mem_state(input logic [3:0] code);
      return (code <= ST_EXEC);
   endfunction

endpackage
`default_nettype wire

// File: rtl/q2_step_edge.sv
`default_nettype none
// ============================================================================
// Module   : q2_step_edge
// Purpose  : Front-panel step rising-edge detector and single-instruction request latch.
// Revision : 1.0 - initial release
// ============================================================================
module q2_step_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_step,
   input  logic i_halted,
   input  logic i_consume,
   output logic o_step_req
);

   logic r_step_prev;
   logic r_step_req;
   logic w_rise;

   assign w_rise = i_step & ~r_step_prev;

   // A request can only be armed while parked, so edges during execution are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_step_prev <= 1'b0;
         r_step_req  <= 1'b0;
      end else begin
         r_step_prev <= i_step;
         if (i_consume) begin
            r_step_req <= 1'b0;
         end else if (w_rise && i_halted) begin
            r_step_req <= 1'b1;
         end
      end
   end

   assign o_step_req = r_step_req;

endmodule
`default_nettype wire

// File: rtl/q2_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : q2_sequencer
// Purpose  : Two-phase state/strobe generator for the Q2 control decoder.
// Revision : 1.0 - initial release
// ============================================================================
module q2_sequencer
   import q2_pkg::*;
#(
   parameter int ALU_STEPS = ALU_STEPS_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic step,
   input  logic o2,
   input  logic mem_rdy,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic ws,
   output logic halted,
   output logic instr_done
);

   localparam logic [3:0] c_ALU_LAST = 4'(int'(ST_ALU0) + ALU_STEPS - 1);

   logic [3:0] r_state;
   phase_e     r_phase;
   logic       r_instr_done;

   logic [3:0] w_state_nxt;
   phase_e     w_phase_nxt;
   logic       w_advance;
   logic       w_consume;
   logic       w_step_req;

   q2_step_edge u_step_edge (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_step     (step),
      .i_halted   (halted),
      .i_consume  (w_consume),
      .o_step_req (w_step_req)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_FETCH;
         r_phase      <= PH_SETTLE;
         r_instr_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_phase      <= w_phase_nxt;
         r_instr_done <= (r_state == ST_EXEC) && (r_phase == PH_WRITE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_advance   = 1'b0;
      if (r_state > c_ALU_LAST) begin
         // Unused ALU codes (or an upset) recover through FETCH.
         w_state_nxt = ST_FETCH;
         w_phase_nxt = PH_SETTLE;
      end else if (r_phase == PH_SETTLE) begin
         w_advance = (!is_mem_state(r_state) || mem_rdy) &&
                     ((r_state != ST_FETCH) || run || w_step_req);
         if (w_advance) begin
            w_phase_nxt = PH_WRITE;
         end
      end else begin
         w_phase_nxt = PH_SETTLE;
         case (r_state)
            ST_FETCH: w_state_nxt = ST_ADDR;
            ST_ADDR:  w_state_nxt = o2 ? ST_EXEC : ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_ALU0;
            ST_EXEC:  w_state_nxt = ST_FETCH;
            default:  w_state_nxt = (r_state == c_ALU_LAST) ? ST_EXEC : (r_state + 4'd1);
         endcase
      end
   end

   assign w_consume  = (r_state == ST_FETCH) && w_advance;
   assign halted     = (r_state == ST_FETCH) && (r_phase == PH_SETTLE) && !run && !w_step_req;
   assign ws         = (r_phase == PH_WRITE);
   assign instr_done = r_instr_done;
   assign s0         = r_state[0];
   assign s1         = r_state[1];
   assign s2         = r_state[2];
   assign s3         = r_state[3];

endmodule
`default_nettype wire
